// File: rtl/f_fetch_reg_if.sv
// Fetch-stage bus: next-PC/IM/hazard inputs in, PC and F/D register contents out.
interface f_fetch_reg_if;
    logic [31:0] NPC;
    logic [31:0] Instr;
    logic        Stall;
    logic        Req;
    logic        D_Eret;
    logic        D_IsBJ;
    logic [31:0] PC;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic [4:0]  D_ExcCode;
    logic        D_BD;
    logic        D_Valid;

    // Surrounding pipeline: drives next-PC, fetched word and control, sees fetch state.
    modport master (
        output NPC, Instr, Stall, Req, D_Eret, D_IsBJ,
        input  PC, D_PC, D_Instr, D_ExcCode, D_BD, D_Valid
    );

    // Fetch-stage state block.
    modport slave (
        input  NPC, Instr, Stall, Req, D_Eret, D_IsBJ,
        output PC, D_PC, D_Instr, D_ExcCode, D_BD, D_Valid
    );
endinterface

// File: rtl/f_fetch_reg.sv
// Fetch-stage state: program counter, fetch address-error detection and the F/D
// pipeline register with stall, exception flush, eret flush and delay-slot tagging.
module f_fetch_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input logic          clk,
    input logic          reset,
    f_fetch_reg_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [4:0]  d_exc_code_q, d_exc_code_d;
    logic        d_bd_q, d_bd_d;
    logic        d_valid_q, d_valid_d;

    logic        f_exc;
    logic [4:0]  f_exc_code;
    logic [31:0] f_instr;

    // Fetch address check on the registered PC; a faulting fetch becomes a nop.
    always_comb begin
        f_exc      = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
        f_exc_code = f_exc ? EXC_ADEL : 5'd0;
        f_instr    = f_exc ? 32'h0 : bus.Instr;
    end

    // Next-state: PC follows NPC unconditionally; F/D by reset > Req > Stall > Eret > advance.
    always_comb begin
        pc_d         = bus.NPC;
        d_pc_d       = d_pc_q;
        d_instr_d    = d_instr_q;
        d_exc_code_d = d_exc_code_q;
        d_bd_d       = d_bd_q;
        d_valid_d    = d_valid_q;
        if (!reset) begin
            pc_d         = RESET_PC;
            d_pc_d       = RESET_PC;
            d_instr_d    = 32'h0;
            d_exc_code_d = 5'd0;
            d_bd_d       = 1'b0;
            d_valid_d    = 1'b0;
        end else if (bus.Req) begin
            d_pc_d       = EXC_PC;
            d_instr_d    = 32'h0;
            d_exc_code_d = 5'd0;
            d_bd_d       = 1'b0;
            d_valid_d    = 1'b0;
        end else if (bus.Stall) begin
            // hold everything in D
        end else if (bus.D_Eret) begin
            // squash the instruction fetched behind eret
            d_pc_d       = pc_q;
            d_instr_d    = 32'h0;
            d_exc_code_d = 5'd0;
            d_bd_d       = 1'b0;
            d_valid_d    = 1'b0;
        end else begin
            d_pc_d       = pc_q;
            d_instr_d    = f_instr;
            d_exc_code_d = f_exc_code;
            d_bd_d       = bus.D_IsBJ;
            d_valid_d    = 1'b1;
        end
    end

    // State registers; reset is folded into the next-state logic above.
    always_ff @(posedge clk) begin
        pc_q         <= pc_d;
        d_pc_q       <= d_pc_d;
        d_instr_q    <= d_instr_d;
        d_exc_code_q <= d_exc_code_d;
        d_bd_q       <= d_bd_d;
        d_valid_q    <= d_valid_d;
    end

    // Outputs come straight from flops.
    always_comb begin
        bus.PC        = pc_q;
        bus.D_PC      = d_pc_q;
        bus.D_Instr   = d_instr_q;
        bus.D_ExcCode = d_exc_code_q;
        bus.D_BD      = d_bd_q;
        bus.D_Valid   = d_valid_q;
    end

endmodule

// File: tb/tb_f_fetch_reg.sv
// Bench for f_fetch_reg: directed test-plan steps followed by random traffic,
// all checked against a behavioural model of the fetch stage.
module tb_f_fetch_reg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] IM_LO    = 32'h0000_3000;
    localparam logic [31:0] IM_HI    = 32'h0000_6FFC;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    f_fetch_reg_if bus ();

    f_fetch_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_dpc, m_dinstr;
    logic [4:0]  m_dcode;
    logic        m_dbd, m_dvalid;

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a < IM_LO) || (a > IM_HI);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".PC"},      bus.PC,               m_pc);
        chk({tag, ".D_PC"},    bus.D_PC,             m_dpc);
        chk({tag, ".D_Instr"}, bus.D_Instr,          m_dinstr);
        chk({tag, ".D_Exc"},   {27'd0, bus.D_ExcCode}, {27'd0, m_dcode});
        chk({tag, ".D_BD"},    {31'd0, bus.D_BD},    {31'd0, m_dbd});
        chk({tag, ".D_Valid"}, {31'd0, bus.D_Valid}, {31'd0, m_dvalid});
    endtask

    // Apply inputs, advance one edge, update the model from the rules, compare.
    task automatic step(input logic rst_n, input logic [31:0] npc, input logic [31:0] instr,
                        input logic stall, input logic req, input logic eret,
                        input logic isbj, input string tag);
        reset      = rst_n;
        bus.NPC    = npc;
        bus.Instr  = instr;
        bus.Stall  = stall;
        bus.Req    = req;
        bus.D_Eret = eret;
        bus.D_IsBJ = isbj;
        @(posedge clk);
        if (!rst_n) begin
            m_dpc = RESET_PC; m_dinstr = 0; m_dcode = 0; m_dbd = 0; m_dvalid = 0;
            m_pc  = RESET_PC;
        end else begin
            if (req) begin
                m_dpc = EXC_PC; m_dinstr = 0; m_dcode = 0; m_dbd = 0; m_dvalid = 0;
            end else if (stall) begin
                // D holds
            end else if (eret) begin
                m_dpc = m_pc; m_dinstr = 0; m_dcode = 0; m_dbd = 0; m_dvalid = 0;
            end else begin
                m_dpc    = m_pc;
                m_dinstr = addr_bad(m_pc) ? 32'h0 : instr;
                m_dcode  = addr_bad(m_pc) ? 5'd4 : 5'd0;
                m_dbd    = isbj;
                m_dvalid = 1'b1;
            end
            m_pc = npc;
        end
        #1;
        chk_all(tag);
    endtask

    logic [31:0] npc_r;
    int          sel;

    initial begin
        m_pc = 'x; m_dpc = 'x; m_dinstr = 'x; m_dcode = 'x; m_dbd = 'x; m_dvalid = 'x;
        reset = 1'b0;
        bus.NPC = 0; bus.Instr = 0; bus.Stall = 0; bus.Req = 0; bus.D_Eret = 0; bus.D_IsBJ = 0;
        @(negedge clk);

        // 1: reset then sequential fetch
        step(0, 32'h0, 32'h2408_0001, 0, 0, 0, 0, "rst0");
        step(0, 32'h0, 32'h2408_0001, 0, 0, 0, 0, "rst1");
        chk("rst.PC_const", bus.PC, 32'h0000_3000);
        chk("rst.Valid_const", {31'd0, bus.D_Valid}, 32'd0);
        step(1, m_pc + 4, 32'h2408_0001, 0, 0, 0, 0, "run0");
        chk("run0.D_PC_const", bus.D_PC, 32'h0000_3000);
        chk("run0.D_Instr_const", bus.D_Instr, 32'h2408_0001);
        step(1, m_pc + 4, 32'h2408_0001, 0, 0, 0, 0, "run1");
        chk("run1.PC_const", bus.PC, 32'h0000_3008);

        // 2: three stalled cycles, then release
        for (int i = 0; i < 3; i++) step(1, m_pc, 32'h1111_2222, 1, 0, 0, 0, "stall");
        chk("stall.D_PC_const", bus.D_PC, 32'h0000_3004);
        step(1, m_pc + 4, 32'h2408_0002, 0, 0, 0, 0, "unstall");
        chk("unstall.D_PC_const", bus.D_PC, 32'h0000_3008);

        // 3: misaligned and out-of-range fetches
        step(1, 32'h0000_3002, 32'h2408_0003, 0, 0, 0, 0, "ld3002");
        step(1, 32'h0000_7000, 32'hdead_beef, 0, 0, 0, 0, "adel3002");
        chk("adel3002.code_const", {27'd0, bus.D_ExcCode}, 32'd4);
        chk("adel3002.D_PC_const", bus.D_PC, 32'h0000_3002);
        step(1, 32'h0000_300C, 32'hdead_beef, 0, 0, 0, 0, "adel7000");
        chk("adel7000.D_PC_const", bus.D_PC, 32'h0000_7000);
        chk("adel7000.instr_const", bus.D_Instr, 32'h0);

        // 5: delay-slot tagging at 300C
        step(1, 32'h0000_3010, 32'h0000_0000, 0, 0, 0, 1, "bd1");
        chk("bd1.BD_const", {31'd0, bus.D_BD}, 32'd1);
        chk("bd1.D_PC_const", bus.D_PC, 32'h0000_300C);
        step(1, 32'h0000_3014, 32'h2408_0004, 0, 0, 0, 0, "bd0");

        // 4: exception request wins over stall
        step(1, EXC_PC, 32'h2408_0005, 1, 1, 0, 0, "req");
        chk("req.D_PC_const", bus.D_PC, 32'h0000_4180);
        chk("req.PC_const", bus.PC, 32'h0000_4180);

        // 6: eret held by stall, flushes on first free edge
        step(1, m_pc + 4, 32'h2408_0006, 0, 0, 0, 0, "pre_eret");
        step(1, m_pc, 32'h2408_0007, 1, 0, 1, 0, "eret_stall");
        step(1, m_pc + 4, 32'h2408_0007, 0, 0, 1, 0, "eret");
        chk("eret.Valid_const", {31'd0, bus.D_Valid}, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      npc_r = m_pc + 4;
            else if (sel < 8) npc_r = IM_LO + ($urandom_range(0, 4095) << 2);
            else if (sel < 9) npc_r = IM_LO + $urandom_range(0, 16383);
            else              npc_r = $urandom;
            step(($urandom_range(0, 29) != 0), npc_r, $urandom,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
